lcd_write_queue: RTL and testbench
==================================

LCD_WRITE_QUEUE -- requirements
Module: LCD_WRITE_QUEUE

Purpose: output stage downstream of the MiniAlu core. It buffers byte writes issued by the core and serialises each one onto a 4-bit HD44780-style LCD bus with fixed timing.

Interface
REQ-001 Parameter DEPTH, default 4: number of FIFO entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter SETUP_CYC, default 2: address/data setup and hold time, in clocks.
REQ-003 Parameter EN_CYC, default 12: E pulse width, in clocks.
REQ-004 Parameter WAIT_CYC, default 2000: post-byte execution wait, in clocks.
REQ-005 Clock  in  1  single system clock; all state updates on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-007 iWrite  in  1  single-cycle write strobe from the core.
REQ-008 iData  in  8  byte to send.
REQ-009 iIsCommand  in  1  1 = instruction byte (RS=0); 0 = character data (RS=1).
REQ-010 oFull  out  1  FIFO holds DEPTH entries.
REQ-011 oBusy  out  1  FIFO non-empty or FSM not IDLE.
REQ-012 oOverflow  out  1  sticky flag: a write was dropped.
REQ-013 oLCD_E  out  1  LCD enable strobe.
REQ-014 oLCD_RS  out  1  LCD register select.
REQ-015 oLCD_RW  out  1  LCD read/write select; SHALL be constant 0.
REQ-016 oLCD_Data  out  4  LCD data nibble.

Function
REQ-017 Each FIFO entry SHALL be 9 bits: {RS, data}, with RS = ~iIsCommand. Order SHALL be first in, first out.
REQ-018 A write SHALL be accepted on a rising edge iff iWrite=1 and count<DEPTH.
REQ-019 A write with iWrite=1 and count=DEPTH SHALL be dropped: FIFO contents unchanged, oOverflow set to 1.
REQ-020 Simultaneous accepted write and pop SHALL leave count unchanged. Read and write pointers SHALL wrap modulo DEPTH.
REQ-021 oFull SHALL equal (count==DEPTH). oFull and oBusy SHALL be registered-state decodes with no combinational path from iWrite.
REQ-022 FSM states SHALL be IDLE, SETUP_HI, PULSE_HI, HOLD_HI, SETUP_LO, PULSE_LO, WAIT.
REQ-023 IDLE: if count>0, the FSM SHALL pop the head entry into a shadow register and go to SETUP_HI on the same edge; otherwise it SHALL stay in IDLE.
REQ-024 SETUP_HI SHALL last SETUP_CYC cycles, PULSE_HI EN_CYC, HOLD_HI SETUP_CYC, SETUP_LO SETUP_CYC, PULSE_LO EN_CYC and WAIT WAIT_CYC, then the FSM SHALL return to IDLE. One byte therefore occupies 1+3*SETUP_CYC+2*EN_CYC+WAIT_CYC cycles.
REQ-025 oLCD_Data SHALL be shadow[7:4] in SETUP_HI, PULSE_HI and HOLD_HI. It SHALL be shadow[3:0] in SETUP_LO, PULSE_LO and WAIT, and 0 in IDLE.
REQ-026 oLCD_RS SHALL be shadow RS from SETUP_HI through WAIT, and 0 in IDLE.
REQ-027 oLCD_E SHALL be 1 only in PULSE_HI and PULSE_LO. All LCD outputs SHALL be registered and glitch-free.
REQ-028 New writes during a transfer SHALL NOT disturb the shadow register or the LCD outputs.

Reset
REQ-029 While Reset=0, all state SHALL be cleared immediately, independent of Clock: state=IDLE, count=0, pointers=0, shadow=0.
REQ-030 While Reset=0, outputs SHALL be: oLCD_E=0, oLCD_RS=0, oLCD_RW=0, oLCD_Data=0, oFull=0, oBusy=0, oOverflow=0.
REQ-031 Reset asserted mid-transfer SHALL drop oLCD_E at once and discard the shadow and all queued entries. No pulse SHALL follow reset release without a new write.
REQ-032 oOverflow SHALL clear only on reset.

Verification (SETUP_CYC=2, EN_CYC=4, WAIT_CYC=10; write at edge 0)
REQ-033 Write 0x41 with iIsCommand=0. Required: RS=1; E high at edges 3-6 with Data=4; E high at edges 11-14 with Data=1; oBusy falls after edge 25; exactly two E pulses.
REQ-034 Write 0x01 with iIsCommand=1. Required: RS=0 throughout; Data=0 during pulse 1, Data=1 during pulse 2; timing identical to REQ-033.
REQ-035 Write 0x10..0x15 on six consecutive edges. Required: oFull=1 after edge 4; write of 0x15 dropped and oOverflow=1; LCD emits 0x10-0x14 in order; oFull=0 after the next pop.
REQ-036 Assert Reset=0 mid-PULSE_HI with 2 entries queued. Required: oLCD_E=0 with no clock edge; after release, no E activity for 50 cycles and oBusy=0.
REQ-037 Create an overflow, then let the queue drain. Required: oOverflow stays 1 after draining and clears only on Reset=0.

Source files
------------

// File: rtl/lcd_write_queue_if.sv
// Core-side write port and 4-bit LCD bus of the LCD write queue.
// The master drives byte writes; the slave returns status and LCD pins.
interface lcd_write_queue_if;
  logic       iWrite;
  logic [7:0] iData;
  logic       iIsCommand;
  logic       oFull;
  logic       oBusy;
  logic       oOverflow;
  logic       oLCD_E;
  logic       oLCD_RS;
  logic       oLCD_RW;
  logic [3:0] oLCD_Data;

  modport master (
    output iWrite, iData, iIsCommand,
    input  oFull, oBusy, oOverflow,
    input  oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );

  modport slave (
    input  iWrite, iData, iIsCommand,
    output oFull, oBusy, oOverflow,
    output oLCD_E, oLCD_RS, oLCD_RW, oLCD_Data
  );
endinterface

// File: rtl/lcd_write_queue.sv
// Byte FIFO feeding a nibble serialiser for a 4-bit HD44780-style LCD.
// Each byte goes out as high then low nibble with fixed setup/pulse/wait timing.
module lcd_write_queue #(
  parameter int DEPTH     = 4,
  parameter int SETUP_CYC = 2,
  parameter int EN_CYC    = 12,
  parameter int WAIT_CYC  = 2000
) (
  input  logic Clock,
  input  logic Reset,
  lcd_write_queue_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, SETUP_HI, PULSE_HI, HOLD_HI,
    SETUP_LO, PULSE_LO, WAIT
  } state_t;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int M1 = (EN_CYC > SETUP_CYC) ? EN_CYC : SETUP_CYC;
  localparam int MAXC = (WAIT_CYC > M1) ? WAIT_CYC : M1;
  localparam int TW = $clog2(MAXC + 1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          overflow;
  logic          full, empty, push, pop;

  state_t        state, state_n;
  logic [TW-1:0] timer, dur;
  logic [8:0]    shadow, shadow_n;
  logic          lcd_e, lcd_rs;
  logic [3:0]    lcd_data;
  logic          e_n, rs_n;
  logic [3:0]    data_n;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign push  = bus.iWrite && !full;
  assign pop   = (state == IDLE) && !empty;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= {~bus.iIsCommand, bus.iData};
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      if (bus.iWrite && full) overflow <= 1'b1;
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state    <= IDLE;
      timer    <= '0;
      shadow   <= '0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      state    <= state_n;
      shadow   <= shadow_n;
      lcd_e    <= e_n;
      lcd_rs   <= rs_n;
      lcd_data <= data_n;
      if (state_n != state || state == IDLE) timer <= '0;
      else timer <= timer + TW'(1);
    end
  end

  always_comb begin
    state_n  = state;
    shadow_n = shadow;
    dur      = TW'(1);
    case (state)
      SETUP_HI, HOLD_HI, SETUP_LO: dur = TW'(SETUP_CYC);
      PULSE_HI, PULSE_LO:          dur = TW'(EN_CYC);
      WAIT:                        dur = TW'(WAIT_CYC);
      default:                     dur = TW'(1);
    endcase
    if (state == IDLE) begin
      if (pop) begin
        state_n  = SETUP_HI;
        shadow_n = mem[rptr];
      end
    end else if (timer == dur - TW'(1)) begin
      case (state)
        SETUP_HI: state_n = PULSE_HI;
        PULSE_HI: state_n = HOLD_HI;
        HOLD_HI:  state_n = SETUP_LO;
        SETUP_LO: state_n = PULSE_LO;
        PULSE_LO: state_n = WAIT;
        default:  state_n = IDLE;
      endcase
    end
  end

  // Decode from the next state so the pins register in step with the FSM.
  always_comb begin
    e_n    = 1'b0;
    rs_n   = 1'b0;
    data_n = '0;
    case (state_n)
      SETUP_HI, PULSE_HI, HOLD_HI: begin
        rs_n   = shadow_n[8];
        data_n = shadow_n[7:4];
        e_n    = (state_n == PULSE_HI);
      end
      SETUP_LO, PULSE_LO, WAIT: begin
        rs_n   = shadow_n[8];
        data_n = shadow_n[3:0];
        e_n    = (state_n == PULSE_LO);
      end
      default: begin
        e_n    = 1'b0;
        rs_n   = 1'b0;
        data_n = '0;
      end
    endcase
  end

  assign bus.oFull     = full;
  assign bus.oBusy     = !empty || (state != IDLE);
  assign bus.oOverflow = overflow;
  assign bus.oLCD_E    = lcd_e;
  assign bus.oLCD_RS   = lcd_rs;
  assign bus.oLCD_RW   = 1'b0;
  assign bus.oLCD_Data = lcd_data;

endmodule

// File: tb/tb_lcd_write_queue.sv
// Directed bench for lcd_write_queue: per-edge timing checks in the main
// thread, byte-level scoreboard in a separate LCD bus monitor.
module tb_lcd_write_queue;
  localparam int DEPTH = 4;
  localparam int SETUP = 2;
  localparam int EN    = 4;
  localparam int WAITC = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_write_queue_if bus();

  lcd_write_queue #(
    .DEPTH(DEPTH), .SETUP_CYC(SETUP),
    .EN_CYC(EN), .WAIT_CYC(WAITC)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus(bus)
  );

  int vectors = 0;
  int errors  = 0;
  logic [8:0] exp_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: assembles two E pulses into one {RS, byte} and scores it.
  initial begin
    bit in_p;
    int plen;
    int half;
    logic [3:0] nib, hi;
    logic rs_c;
    in_p = 0; plen = 0; half = 0;
    nib = '0; hi = '0; rs_c = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_p = 0;
        half = 0;
      end else if (bus.oLCD_E) begin
        if (!in_p) begin
          in_p = 1;
          plen = 0;
          nib  = bus.oLCD_Data;
          rs_c = bus.oLCD_RS;
        end
        plen++;
      end else if (in_p) begin
        in_p = 0;
        chk("pulse_width", plen, EN);
        if (half == 0) begin
          hi   = nib;
          half = 1;
        end else begin
          half = 0;
          if (exp_q.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL spurious_byte: got %0h expected none",
                     {rs_c, hi, nib});
          end else begin
            chk("lcd_byte", {rs_c, hi, nib}, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic single(logic [7:0] b, logic cmd);
    int rises;
    logic pe, exp_e, rs_exp;
    rs_exp = ~cmd;
    exp_q.push_back({rs_exp, b});
    @(negedge clk);
    bus.iWrite = 1'b1;
    bus.iData = b;
    bus.iIsCommand = cmd;
    @(posedge clk); #1;
    bus.iWrite = 1'b0;
    chk("busy_edge0", bus.oBusy, 1);
    rises = 0;
    pe = 1'b0;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      exp_e = (k >= 3 && k <= 6) || (k >= 11 && k <= 14);
      chk($sformatf("e_edge%0d", k), bus.oLCD_E, exp_e);
      if (bus.oLCD_E && !pe) rises++;
      pe = bus.oLCD_E;
      if (k >= 3 && k <= 6)
        chk($sformatf("data_hi%0d", k), bus.oLCD_Data, b[7:4]);
      if (k >= 11 && k <= 14)
        chk($sformatf("data_lo%0d", k), bus.oLCD_Data, b[3:0]);
      if (k <= 24)
        chk($sformatf("rs_edge%0d", k), bus.oLCD_RS, rs_exp);
      if (k == 24) chk("busy_edge24", bus.oBusy, 1);
      if (k == 25) begin
        chk("busy_edge25", bus.oBusy, 0);
        chk("idle_data", bus.oLCD_Data, 0);
        chk("idle_rs", bus.oLCD_RS, 0);
      end
    end
    chk("pulse_count", rises, 2);
  endtask

  task automatic check_reset_outs(string tag);
    chk({tag, "_e"}, bus.oLCD_E, 0);
    chk({tag, "_rs"}, bus.oLCD_RS, 0);
    chk({tag, "_rw"}, bus.oLCD_RW, 0);
    chk({tag, "_data"}, bus.oLCD_Data, 0);
    chk({tag, "_full"}, bus.oFull, 0);
    chk({tag, "_busy"}, bus.oBusy, 0);
    chk({tag, "_ovf"}, bus.oOverflow, 0);
  endtask

  initial begin
    int t;
    int e_cnt;
    logic [8:0] v;
    bus.iWrite = 1'b0;
    bus.iData = '0;
    bus.iIsCommand = 1'b0;

    #1;
    check_reset_outs("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    single(8'h41, 1'b0);
    single(8'h01, 1'b1);

    // Six back-to-back writes into a 4-deep queue.
    for (int i = 0; i < 5; i++) begin
      v = 9'h110 + 9'(i);
      exp_q.push_back(v);
    end
    @(negedge clk);
    bus.iWrite = 1'b1;
    bus.iIsCommand = 1'b0;
    bus.iData = 8'h10;
    for (int e = 0; e <= 26; e++) begin
      @(posedge clk); #1;
      if (e == 3) chk("full_edge3", bus.oFull, 0);
      if (e == 4) begin
        chk("full_edge4", bus.oFull, 1);
        chk("ovf_edge4", bus.oOverflow, 0);
      end
      if (e == 5) chk("ovf_edge5", bus.oOverflow, 1);
      if (e == 25) chk("full_edge25", bus.oFull, 1);
      if (e == 26) chk("full_edge26", bus.oFull, 0);
      if (e < 5) bus.iData = 8'h11 + 8'(e);
      else bus.iWrite = 1'b0;
    end
    t = 0;
    while (bus.oBusy && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_busy", bus.oBusy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", bus.oOverflow, 1);
    chk("queue_drained", exp_q.size(), 0);

    // Reset in the middle of the first high-nibble pulse.
    @(negedge clk);
    bus.iWrite = 1'b1;
    bus.iIsCommand = 1'b0;
    bus.iData = 8'hA1;
    @(posedge clk); #1;
    bus.iData = 8'hB2;
    @(posedge clk); #1;
    bus.iData = 8'hC3;
    @(posedge clk); #1;
    bus.iWrite = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_e", bus.oLCD_E, 1);
    @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset_outs("midrst");
    exp_q.delete();
    @(negedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    e_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (bus.oLCD_E) e_cnt++;
    end
    chk("post_rst_e", e_cnt, 0);
    chk("post_rst_busy", bus.oBusy, 0);
    chk("post_rst_ovf", bus.oOverflow, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
